pc_tx_arbiter: RTL



---
 rtl/pc_tx_arbiter_if.sv | 37 +++
 rtl/pc_tx_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_tx_arbiter_if.sv
// Bus bundle between the upstream word sources, the arbiter and the PC TX FIFO write port.
// The master modport is the arbiter's view; the slave modport is the producer/FIFO side.
interface pc_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ*32-1:0] i_req_word;
    logic [NUM_REQ-1:0]    o_ack;
    logic [31:0]           o_fifo_word_data;
    logic                  o_fifo_wr;
    logic                  i_fifo_full;
    logic [ID_W-1:0]       o_grant_id;
    logic                  o_busy;

    modport master (
        input  i_req,
        input  i_req_word,
        input  i_fifo_full,
        output o_ack,
        output o_fifo_word_data,
        output o_fifo_wr,
        output o_grant_id,
        output o_busy
    );

    modport slave (
        output i_req,
        output i_req_word,
        output i_fifo_full,
        input  o_ack,
        input  o_fifo_word_data,
        input  o_fifo_wr,
        input  o_grant_id,
        input  o_busy
    );
endinterface

// File: rtl/pc_tx_arbiter.sv
// Round-robin arbiter feeding the PC TX word FIFO: one word per two cycles, bursts of up to MAX_BURST.
// Optional header word per new grant when PC_TX_ARB_HDR_EN is defined.
module pc_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 3
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    pc_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               wr_q, wr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [7:0]         cnt_q, cnt_d;
`ifdef PC_TX_ARB_HDR_EN
    logic               hdr_pend_q, hdr_pend_d;
`endif

    logic [31:0]        word_s [NUM_REQ];
    logic [ID_W-1:0]    cand_s [NUM_REQ];
    logic [NUM_REQ-1:0] hit_s;
    logic               arb_found;
    logic [ID_W-1:0]    arb_idx;
    logic [31:0]        arb_word;
    logic [31:0]        cont_word;
    logic               cont_req;
    logic               new_grant;
    logic               cont_grant;

    // cand_s[gi] is the requester index at search offset gi+1 from the last grant
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [ID_W:0] sum_s;
        assign word_s[gi] = bus.i_req_word[32*gi +: 32];
        assign sum_s      = {1'b0, last_q} + (ID_W+1)'(gi + 1);
        assign cand_s[gi] = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ))
                                                          : sum_s[ID_W-1:0];
        assign hit_s[gi]  = |(bus.i_req & (NUM_REQ'(1) << cand_s[gi]));
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                arb_found = 1'b1;
                arb_idx   = cand_s[i];
            end
        end
    end

    always_comb begin
        arb_word  = '0;
        cont_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) arb_word = word_s[i];
            if (grant_q == ID_W'(i)) cont_word = word_s[i];
        end
    end

    assign cont_req = |(bus.i_req & (NUM_REQ'(1) << grant_q));

    // Full and requests are only looked at in IDLE/GAP, so a committed SEND always completes
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ack_d      = '0;
        wr_d       = 1'b0;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        new_grant  = 1'b0;
        cont_grant = 1'b0;
`ifdef PC_TX_ARB_HDR_EN
        hdr_pend_d = hdr_pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!bus.i_fifo_full && arb_found) new_grant = 1'b1;
            end
            SEND: begin
                state_d = GAP;
            end
            GAP: begin
`ifdef PC_TX_ARB_HDR_EN
                if (hdr_pend_q) begin
                    if (bus.i_fifo_full) begin
                        state_d = GAP;
                    end else if (cont_req) begin
                        cont_grant = 1'b1;
                    end else begin
                        hdr_pend_d = 1'b0;
                        if (arb_found) new_grant = 1'b1;
                        else           state_d = IDLE;
                    end
                end else
`endif
                if (cont_req && !bus.i_fifo_full && (cnt_q < 8'(MAX_BURST))) begin
                    cont_grant = 1'b1;
                end else if (!bus.i_fifo_full && arb_found) begin
                    new_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_grant) begin
            state_d = SEND;
            wr_d    = 1'b1;
            grant_d = arb_idx;
            last_d  = arb_idx;
`ifdef PC_TX_ARB_HDR_EN
            data_d     = 32'hA500_0000 | (32'(arb_idx) << 16);
            cnt_d      = 8'd0;
            hdr_pend_d = 1'b1;
`else
            data_d  = arb_word;
            ack_d   = NUM_REQ'(1) << arb_idx;
            cnt_d   = 8'd1;
`endif
        end

        if (cont_grant) begin
            state_d = SEND;
            wr_d    = 1'b1;
            data_d  = cont_word;
            ack_d   = NUM_REQ'(1) << grant_q;
`ifdef PC_TX_ARB_HDR_EN
            cnt_d      = hdr_pend_q ? 8'd1 : cnt_q + 8'd1;
            hdr_pend_d = 1'b0;
`else
            cnt_d   = cnt_q + 8'd1;
`endif
        end
    end

    // last_q starts at NUM_REQ-1 so the first search begins at requester 0
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            ack_q      <= '0;
            wr_q       <= 1'b0;
            grant_q    <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            cnt_q      <= '0;
`ifdef PC_TX_ARB_HDR_EN
            hdr_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            wr_q       <= wr_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
`ifdef PC_TX_ARB_HDR_EN
            hdr_pend_q <= hdr_pend_d;
`endif
        end
    end

    assign bus.o_ack            = ack_q;
    assign bus.o_fifo_wr        = wr_q;
    assign bus.o_fifo_word_data = data_q;
    assign bus.o_grant_id       = grant_q;
    assign bus.o_busy           = (state_q != IDLE);

endmodule
